mipi_rx_lane_ctrl: RTL
======================

MIPI_RX_LANE_CTRL -- requirements
Module: mipi_rx_lane_ctrl

Interface
REQ-001 SHALL have parameter TSETTLE, default 6, meaning BYTECLK cycles in LP-00 before the HS deserializer is enabled; legal range 1..255.
REQ-002 SHALL have parameter SYNC_TIMEOUT, default 32, meaning maximum SEARCH cycles allowed before a sync error; legal range 1..255.
REQ-003 SHALL have port BYTECLK, input, 1, the single clock for all logic.
REQ-004 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 SHALL have port DRXLPP, input, 1, LP receiver P output, asynchronous to BYTECLK.
REQ-006 SHALL have port DRXLPN, input, 1, LP receiver N output, asynchronous to BYTECLK.
REQ-007 SHALL have port HSRXDATA, input, 8, raw unaligned deserializer byte, LSB received first.
REQ-008 SHALL have port RXHSEN, output, 1, HS receiver and termination enable.
REQ-009 SHALL have port HSDESEREN, output, 1, deserializer enable.
REQ-010 SHALL have port DATA, output, 8, aligned payload byte.
REQ-011 SHALL have port DATAVALID, output, 1, DATA qualifier.
REQ-012 SHALL have port SYNC, output, 1, high while byte-locked.
REQ-013 SHALL have port ERRSYNC, output, 1, one-cycle pulse on sync timeout.
REQ-014 SHALL have port SOTERR, output, 1, one-cycle pulse on a tolerated sync-byte bit error; held at 0 without MIPI_RX_SOT_ERR_TOL_EN.

Function
REQ-015 SHALL pass DRXLPP and DRXLPN through a 2-flop synchronizer; LP = {P,N} after synchronization; all decisions use LP.
REQ-016 SHALL implement states IDLE, HSRQST, SETTLE, SEARCH, HSDATA and WAITSTOP.
REQ-017 IDLE: exit to HSRQST when LP=01; otherwise remain.
REQ-018 HSRQST: exit to SETTLE when LP=00; exit to IDLE when LP=11 or LP=10 (escape mode not supported; treated as abort).
REQ-019 SETTLE: RXHSEN=1; an 8-bit counter is cleared on entry; exit to SEARCH after TSETTLE cycles; exit to IDLE when LP=11.
REQ-020 SEARCH: RXHSEN=1 and HSDESEREN=1.
REQ-021 SEARCH: form window W={HSRXDATA, prev}, where prev is the previous-cycle HSRXDATA, and compare W[k+7:k] with 8'hB8 for k=0..7.
REQ-022 SEARCH: the lowest matching k SHALL win and be latched as the offset; then go to HSDATA.
REQ-023 SEARCH: exit to WAITSTOP with ERRSYNC pulsed after SYNC_TIMEOUT cycles without a match; exit to IDLE when LP=11.
REQ-024 HSDATA: SYNC=1; DATA=W[off+7:off] and DATAVALID=1 every cycle, the first valid byte one cycle after the match cycle.
REQ-025 HSDATA: a match and LP=11 in the same SEARCH cycle SHALL resolve to IDLE (LP=11 wins).
REQ-026 HSDATA: exit to IDLE when LP=11; DATAVALID, SYNC, RXHSEN and HSDESEREN SHALL be 0 from that cycle's registered outputs onward.
REQ-027 WAITSTOP: all enables SHALL be 0; exit to IDLE when LP=11.
REQ-028 All outputs SHALL be registered; DATA SHALL hold its last value when DATAVALID=0.
REQ-029 Counters SHALL saturate and SHALL never wrap.

Reset
REQ-030 On RESET=1 at a BYTECLK edge: state=IDLE, synchronizers=2'b11, counters=0, offset=0, prev=0.
REQ-031 On RESET=1 at a BYTECLK edge: RXHSEN=0, HSDESEREN=0, DATA=8'h00, DATAVALID=0, SYNC=0, ERRSYNC=0, SOTERR=0.
REQ-032 RESET mid-burst SHALL take effect on the next edge with no further DATAVALID.

Configuration
REQ-033 When MIPI_RX_SOT_ERR_TOL_EN is defined, SEARCH SHALL also accept a candidate at Hamming distance 1 from 8'hB8.
REQ-034 With MIPI_RX_SOT_ERR_TOL_EN defined, an exact match at any k SHALL take priority over a 1-bit match, and a 1-bit-match lock SHALL pulse SOTERR for one cycle.
REQ-035 When MIPI_RX_SOT_ERR_TOL_EN is undefined, only an exact match SHALL lock and SOTERR SHALL be tied to 0.

Verification
REQ-036 LP 11->01->00 with TSETTLE=6: RXHSEN rises on SETTLE entry, and HSDESEREN rises exactly 6 cycles later.
REQ-037 Sync at offset 3, then payload 8'h12, 8'h34 -> SYNC=1; DATA 8'h12 then 8'h34, first DATAVALID one cycle after the match cycle.
REQ-038 No 8'hB8 for 32 SEARCH cycles -> ERRSYNC high for exactly one cycle; state WAITSTOP; no DATAVALID until after LP=11.
REQ-039 LP returns to 11 after 4 payload bytes -> exactly 4 DATAVALID cycles; RXHSEN=0 and SYNC=0 thereafter.
REQ-040 Sync byte 8'hB9: with MIPI_RX_SOT_ERR_TOL_EN defined -> lock with one SOTERR pulse; undefined -> ERRSYNC after timeout.
REQ-041 RESET asserted during HSDATA -> all outputs at reset values on the next edge; a new 11->01->00 sequence locks normally.

Source files
------------

// File: rtl/mipi_rx_lane_ctrl.sv
// MIPI D-PHY RX data lane control: LP entry, HS settle, sync search, byte alignment.
// Optional 1-bit sync-byte tolerance enabled by `define MIPI_RX_SOT_ERR_TOL_EN.
module mipi_rx_lane_ctrl #(
  parameter int unsigned TSETTLE      = 6,
  parameter int unsigned SYNC_TIMEOUT = 32
) (
  input  logic       BYTECLK,
  input  logic       RESET,
  input  logic       DRXLPP,
  input  logic       DRXLPN,
  input  logic [7:0] HSRXDATA,
  output logic       RXHSEN,
  output logic       HSDESEREN,
  output logic [7:0] DATA,
  output logic       DATAVALID,
  output logic       SYNC,
  output logic       ERRSYNC,
  output logic       SOTERR
);

  localparam logic [7:0] SYNC_BYTE   = 8'hB8;
  localparam logic [7:0] SETTLE_LAST = 8'(TSETTLE - 1);
  localparam logic [7:0] SEARCH_LAST = 8'(SYNC_TIMEOUT - 1);
  localparam logic [7:0] CNT_MAX     = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    HSRQST,
    SETTLE,
    SEARCH,
    HSDATA,
    WAITSTOP
  } state_t;

  state_t      state;
  logic [1:0]  lp_s1;
  logic [1:0]  lp;
  logic [7:0]  prev;
  logic [15:0] win;
  logic [7:0]  cnt;
  logic [2:0]  off;
  logic        exact_hit;
  logic [2:0]  exact_off;
  logic        lock_hit;
  logic [2:0]  lock_off;
  logic        lock_err;
  logic [7:0]  data_w;

  // Two-flop synchronizer on the LP pair; stop state (11) out of reset
  always_ff @(posedge BYTECLK) begin
    if (RESET) begin
      lp_s1 <= 2'b11;
      lp    <= 2'b11;
    end else begin
      lp_s1 <= {DRXLPP, DRXLPN};
      lp    <= lp_s1;
    end
  end

  // Previous raw byte, lower half of the 16-bit alignment window
  always_ff @(posedge BYTECLK) begin
    if (RESET) prev <= 8'h00;
    else       prev <= HSRXDATA;
  end

  assign win    = {HSRXDATA, prev};
  assign data_w = win[off +: 8];

  // Lowest bit offset holding an exact sync byte
  always_comb begin
    exact_hit = 1'b0;
    exact_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == SYNC_BYTE) begin
        exact_hit = 1'b1;
        exact_off = 3'(k);
      end
    end
  end

`ifdef MIPI_RX_SOT_ERR_TOL_EN
  logic       near_hit;
  logic [2:0] near_off;

  function automatic logic one_bit_off(input logic [7:0] b);
    logic [7:0] x;
    x = b ^ SYNC_BYTE;
    return (x != 8'd0) && ((x & (x - 8'd1)) == 8'd0);
  endfunction

  // Lowest bit offset holding a sync byte with one flipped bit
  always_comb begin
    near_hit = 1'b0;
    near_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (one_bit_off(win[k +: 8])) begin
        near_hit = 1'b1;
        near_off = 3'(k);
      end
    end
  end

  assign lock_hit = exact_hit | near_hit;
  assign lock_off = exact_hit ? exact_off : near_off;
  assign lock_err = ~exact_hit & near_hit;
`else
  assign lock_hit = exact_hit;
  assign lock_off = exact_off;
  assign lock_err = 1'b0;
`endif

  // Lane FSM; every output is registered alongside the state
  always_ff @(posedge BYTECLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      off       <= 3'd0;
      RXHSEN    <= 1'b0;
      HSDESEREN <= 1'b0;
      DATA      <= 8'h00;
      DATAVALID <= 1'b0;
      SYNC      <= 1'b0;
      ERRSYNC   <= 1'b0;
      SOTERR    <= 1'b0;
    end else begin
      DATAVALID <= 1'b0;
      ERRSYNC   <= 1'b0;
      SOTERR    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lp == 2'b01) state <= HSRQST;
        end
        HSRQST: begin
          if (lp == 2'b00) begin
            state  <= SETTLE;
            cnt    <= 8'd0;
            RXHSEN <= 1'b1;
          end else if (lp[1]) begin
            state <= IDLE;
          end
        end
        SETTLE: begin
          if (lp == 2'b11) begin
            state  <= IDLE;
            RXHSEN <= 1'b0;
          end else if (cnt >= SETTLE_LAST) begin
            state     <= SEARCH;
            cnt       <= 8'd0;
            HSDESEREN <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
          end
        end
        SEARCH: begin
          if (lp == 2'b11) begin
            state     <= IDLE;
            RXHSEN    <= 1'b0;
            HSDESEREN <= 1'b0;
          end else if (lock_hit) begin
            state  <= HSDATA;
            off    <= lock_off;
            SYNC   <= 1'b1;
            SOTERR <= lock_err;
          end else if (cnt >= SEARCH_LAST) begin
            state     <= WAITSTOP;
            ERRSYNC   <= 1'b1;
            RXHSEN    <= 1'b0;
            HSDESEREN <= 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
          end
        end
        HSDATA: begin
          if (lp == 2'b11) begin
            state     <= IDLE;
            RXHSEN    <= 1'b0;
            HSDESEREN <= 1'b0;
            SYNC      <= 1'b0;
          end else begin
            DATA      <= data_w;
            DATAVALID <= 1'b1;
          end
        end
        WAITSTOP: begin
          if (lp == 2'b11) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
